mvm_accum_collect: RTL and testbench

- Downstream neighbour of the MVM control FSM.
- Consumes per-beat dot-product results from one output lane, tagged with the FSM's first/last flags after datapath delay-matching.
- Accumulates each row's partial products into one result and queues completed results in a small FIFO.
- Drains the FIFO to the output interface with a valid/ready handshake. The upstream FSM cannot stall, so any overflow is flagged rather than back-pressured.

---
 rtl/mvm_accum_collect_if.sv | 29 ++
 rtl/mvm_accum_collect.sv | 91 +++++++++
 tb/tb_mvm_accum_collect.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mvm_accum_collect_if.sv
// Beat input and result output bundle for mvm_accum_collect.
// master drives beats and oready; slave is the collector.
interface mvm_accum_collect_if #(
    parameter int IWIDTH = 32,
    parameter int OWIDTH = 32,
    parameter int CNTW   = 5
);
    logic                     ivalid;
    logic signed [IWIDTH-1:0] idata;
    logic                     ifirst;
    logic                     ilast;
    logic [OWIDTH-1:0]        odata;
    logic                     ovalid;
    logic                     oready;
    logic [CNTW-1:0]          count;
    logic                     full;
    logic                     overflow;
    logic                     busy;

    modport master (
        output ivalid, idata, ifirst, ilast, oready,
        input  odata, ovalid, count, full, overflow, busy
    );

    modport slave (
        input  ivalid, idata, ifirst, ilast, oready,
        output odata, ovalid, count, full, overflow, busy
    );
endinterface

// File: rtl/mvm_accum_collect.sv
// Row accumulator for one MVM output lane with a FWFT result FIFO.
// Upstream cannot stall, so a push into a full FIFO is dropped and flagged.
module mvm_accum_collect #(
    parameter int IWIDTH = 32,
    parameter int OWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int CNTW   = $clog2(DEPTH+1)
) (
    input  logic               clk,
    input  logic               rst,
    mvm_accum_collect_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic signed [OWIDTH-1:0] sum;
    logic signed [OWIDTH-1:0] acc_q, acc_d;
    logic [OWIDTH-1:0]        mem_q [DEPTH];
    logic [AW-1:0]            wptr_q, wptr_d;
    logic [AW-1:0]            rptr_q, rptr_d;
    logic [CNTW-1:0]          count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic                     busy_q, busy_d;
    logic                     push, pop, wr_en;
    logic                     full_w, ovalid_w;

    assign sum      = OWIDTH'($signed(bus.idata));
    assign full_w   = (count_q == CNTW'(DEPTH));
    assign ovalid_w = (count_q != '0);
    assign pop      = ovalid_w & bus.oready;
    assign push     = bus.ivalid & bus.ilast;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_en    = push & (~full_w | pop);

    // Next-state for accumulator, row tracking, pointers and occupancy.
    always_comb begin
        acc_d   = acc_q;
        busy_d  = busy_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | (push & full_w & ~pop);
        if (bus.ivalid) begin
            acc_d = bus.ifirst ? sum : acc_q + sum;
            if (bus.ilast)
                busy_d = 1'b0;
            else if (bus.ifirst)
                busy_d = 1'b1;
        end
        if (wr_en)
            wptr_d = wptr_q + AW'(1);
        if (pop)
            rptr_d = rptr_q + AW'(1);
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Result storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wptr_q] <= acc_d;
    end

    // Control and accumulator state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            busy_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.odata    = ovalid_w ? mem_q[rptr_q] : '0;
    assign bus.ovalid   = ovalid_w;
    assign bus.count    = count_q;
    assign bus.full     = full_w;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mvm_accum_collect.sv
// Testbench for mvm_accum_collect: vector table plus corner sequences.
// Results are queued when the last beat is driven and checked on pop.
module tb_mvm_accum_collect;
    localparam int IW = 32;
    localparam int OW = 32;
    localparam int D  = 16;
    localparam int CW = $clog2(D+1);

    typedef struct {
        logic        v;
        logic        f;
        logic        l;
        logic [31:0] d;
        logic        rdy;
        logic [31:0] res;
        logic        eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mvm_accum_collect_if #(.IWIDTH(IW), .OWIDTH(OW), .CNTW(CW)) bus ();

    mvm_accum_collect #(
        .IWIDTH(IW), .OWIDTH(OW), .DEPTH(D), .CNTW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] q[$];
    logic        ovf_m = 1'b0;
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic f, input logic l,
                                input logic [31:0] d, input logic rdy,
                                input logic [31:0] res, input logic eb);
        vec_t x;
        x.v = v; x.f = f; x.l = l; x.d = d;
        x.rdy = rdy; x.res = res; x.eb = eb;
        return x;
    endfunction

    task automatic step(input vec_t x);
        logic pop, push, drop;
        bus.ivalid = x.v;
        bus.ifirst = x.f;
        bus.ilast  = x.l;
        bus.idata  = x.d;
        bus.oready = x.rdy;
        @(negedge clk);
        pop = x.rdy && (q.size() != 0);
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("ovalid", 32'(bus.ovalid), 32'(q.size() != 0));
        chk("full", 32'(bus.full), 32'(q.size() == D));
        chk("overflow", 32'(bus.overflow), 32'(ovf_m));
        if (q.size() != 0)
            chk("odata", bus.odata, q[0]);
        push = x.v && x.l;
        drop = push && (q.size() == D) && !pop;
        @(posedge clk);
        #1;
        if (pop)
            void'(q.pop_front());
        if (push && !drop)
            q.push_back(x.res);
        if (drop)
            ovf_m = 1'b1;
        chk("busy", 32'(bus.busy), 32'(x.eb));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.ivalid = 1'b0;
        bus.ifirst = 1'b0;
        bus.ilast  = 1'b0;
        bus.idata  = '0;
        bus.oready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
        chk("rst_odata", bus.odata, 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        // accumulate onto reset acc without a first beat
        tbl.push_back(mk(1, 0, 1, 32'd6, 1, 32'd6, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));
        // single row 1+2+3+4
        tbl.push_back(mk(1, 1, 0, 32'd1, 1, 32'd0, 1));
        tbl.push_back(mk(1, 0, 0, 32'd2, 1, 32'd0, 1));
        tbl.push_back(mk(1, 0, 0, 32'd3, 1, 32'd0, 1));
        tbl.push_back(mk(1, 0, 1, 32'd4, 1, 32'd10, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));
        // single-word rows held, then drained
        tbl.push_back(mk(1, 1, 1, 32'hFFFFFFFB, 0, 32'hFFFFFFFB, 0));
        tbl.push_back(mk(1, 1, 1, 32'd7, 0, 32'd7, 0));
        tbl.push_back(mk(1, 1, 1, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 0, 32'd0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));
        // wrap, with an ignored invalid beat mid-row
        tbl.push_back(mk(1, 1, 0, 32'h7FFFFFFF, 1, 32'd0, 1));
        tbl.push_back(mk(0, 1, 1, 32'hDEADBEEF, 1, 32'd0, 1));
        tbl.push_back(mk(1, 0, 1, 32'd1, 1, 32'h80000000, 0));
        tbl.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 1, 32'd0, 1));
        tbl.push_back(mk(1, 0, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));
        tbl.push_back(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i]);

        // full plus simultaneous pop
        for (int i = 1; i <= D; i++)
            step(mk(1, 1, 1, 32'(i), 0, 32'(i), 0));
        step(mk(1, 1, 1, 32'd99, 1, 32'd99, 0));
        step(mk(0, 0, 0, 32'd0, 0, 32'd0, 0));
        for (int i = 0; i <= D; i++)
            step(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));

        // overflow: 17th result dropped, flag sticky
        do_reset();
        for (int i = 1; i <= D + 1; i++)
            step(mk(1, 1, 1, 32'(i), 0, 32'(i), 0));
        step(mk(0, 0, 0, 32'd0, 0, 32'd0, 0));
        for (int i = 0; i <= D; i++)
            step(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));

        // reset mid-row discards the partial sum
        do_reset();
        step(mk(1, 1, 0, 32'd5, 1, 32'd0, 1));
        do_reset();
        step(mk(1, 1, 0, 32'd2, 1, 32'd0, 1));
        step(mk(1, 0, 1, 32'd3, 1, 32'd5, 0));
        step(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));
        step(mk(0, 0, 0, 32'd0, 1, 32'd0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
